ir_batch_controller: RTL and testbench
======================================

# ir_batch_controller

Parametrised successor to the input-router coordinate controller. It walks a rectangular output feature map of independent width and height, with configurable stride, across `i_ch_groups` channel groups. It issues coordinates in batches of up to `ROW_COUNT` to the row routers, with per-coordinate backpressure and a row-valid mask for partial final batches. It then sequences tile comparison and data drain, and sits between the top-level layer controller and the address generator, address comparator, tile reader and row-router FIFOs.

## Interface
- `ROW_COUNT`, 4: row routers per batch; must be ≥2.
- `ADDR_WIDTH`, 8: coordinate/size width.
- `CH_WIDTH`, 4: channel-group counter width.
- `RID_W`, `$clog2(ROW_COUNT)`: row-id width (localparam).

- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_en`  in  1  start; sampled in IDLE.
- `i_reg_clear`  in  1  synchronous clear; same effect as reset.
- `i_o_w`, `i_o_h`  in  ADDR_WIDTH  output width/height in positions; sampled on start.
- `i_stride`  in  ADDR_WIDTH  stride; sampled on start.
- `i_ch_groups`  in  CH_WIDTH  number of channel groups; sampled on start.
- `i_rr_ready`  in  1  row routers can accept a coordinate.
- `i_addr_empty`, `i_data_empty`, `i_pop_en`  in  1  router status and pop request.
- `o_row_id`  out  RID_W  row router addressed.
- `o_row_valid`  out  ROW_COUNT  rows loaded in the current batch.
- `o_o_x`, `o_o_y`  out  ADDR_WIDTH  input-space coordinate (index × stride).
- `o_ch_group`  out  CH_WIDTH  current channel group.
- `o_ag_en`, `o_ac_en`, `o_tile_read_en`, `o_pop_en`  out  1  downstream enables.
- `o_ready`, `o_reg_clear`, `o_context_done`, `o_done`, `o_busy`  out  1  status.

## Operation
- All outputs are registered. On reset or `i_reg_clear`, every output is 0 and the state is IDLE.
- **States:** IDLE → INIT → GEN → WSTALL → TCMP → DRAIN → (INIT | IDLE).
- **IDLE**
  - On `i_en` with `o_done`=0, latch the sizes and go to INIT.
  - If `i_o_w`, `i_o_h` or `i_ch_groups` is 0, set `o_done`=1 directly and stay in IDLE. No enables are asserted.
  - `o_done` is sticky until `i_reg_clear` or reset.
- **INIT**
  - Clear `o_context_done` and `o_ready`.
  - Set `o_row_id`=0 and `o_row_valid`=0.
  - `o_busy`=1 in all non-IDLE states.
- **Scan order**
  - y fastest, then x, then channel group.
  - Indices are compared against `w-1`/`h-1`; no multiplier is used.
  - Coordinates accumulate by adding `i_stride`, wrapping mod 2^ADDR_WIDTH.
- **GEN**
  - Each issued coordinate: `o_ag_en`=1, the coordinate on `o_o_x`/`o_o_y`/`o_ch_group`/`o_row_id`, and `o_row_valid[o_row_id]` set.
  - Issue happens only when `i_rr_ready`=1. Otherwise `o_ag_en`=0 and all coordinate outputs hold.
  - The batch ends after the coordinate with `o_row_id`=ROW_COUNT-1, or after the last coordinate of the channel group, whichever comes first.
  - At batch end: `o_ag_en`=0, go to WSTALL, and pre-advance the scan position.
- **WSTALL:** one cycle, then TCMP.
- **TCMP**
  - `o_tile_read_en`=`o_ac_en`=1 until `i_addr_empty`.
  - Then both go to 0, `o_ready`=1, `o_pop_en`=1, and the state moves to DRAIN.
- **DRAIN**
  - `o_pop_en` stays 1 while `i_pop_en` or no empty.
  - On `i_data_empty`: `o_pop_en`=0, `o_ready`=0, and `o_reg_clear` pulses for 1 cycle.
  - If that was the final batch of the final group: `o_done`=1, go to IDLE.
  - Otherwise go to INIT. `o_context_done` is 1 in INIT for a non-final batch within the same group (weight reuse), and 0 when the group changes.

## Timing
- The first coordinate is issued 2 cycles after `i_en` is sampled.
- Coordinates are issued at 1 per cycle under continuous `i_rr_ready`.
- `i_rr_ready` low in cycle N gives `o_ag_en`=0 in cycle N+1.
- A full batch takes ROW_COUNT cycles in GEN, plus 1 WSTALL cycle, plus at least 1 TCMP cycle.
- `i_addr_empty` and `i_data_empty` asserted on entry to their states give 1-cycle TCMP/DRAIN occupancy.
- Reset or `i_reg_clear` mid-batch aborts immediately. No partial `o_done` is produced.
- `i_en` outside IDLE is ignored.

## Configuration
- **With `IR_BATCH_PERF_CNT_EN`:**
  - Adds outputs `o_stall_cycles` [31:0] (GEN cycles with `i_rr_ready`=0) and `o_batch_count` [15:0] (batches completed).
  - Both clear on reset, `i_reg_clear`, or an accepted start; they saturate rather than wrap.
- **Without it:** these ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- **Full batches:** w=2, h=2, stride=1, groups=1, ROW_COUNT=4, `i_rr_ready`=1 → coordinates (x,y) = (0,0),(0,1),(1,0),(1,1); `o_row_valid`=4'b1111; one `o_reg_clear`; `o_done`=1, `o_context_done` never high.
- **Stride and partial batch:** w=1, h=5, stride=2 → batch 1 y = 0,2,4,6 with `o_context_done`=1; batch 2 y=8 with `o_row_valid`=4'b0001, then `o_done`.
- **Backpressure:** drop `i_rr_ready` for 3 cycles after the 2nd coordinate → `o_ag_en` low for exactly 3 cycles; coordinate held; no duplicate or skipped coordinates.
- **Channel groups:** groups=2, w=h=2 → 8 coordinates; `o_ch_group` goes 0 to 1 after the 4th; `o_context_done`=0 at the group change; `o_done` after the 2nd drain.
- **Zero size:** h=0 → `o_done`=1 the cycle after start; `o_ag_en`, `o_ac_en`, `o_tile_read_en` and `o_pop_en` never assert.
- **Reset mid-operation:** assert `i_rst` in TCMP → all outputs 0 asynchronously; a new start then runs the full scan correctly.

Source files
------------

// File: rtl/ir_batch_controller.sv
// ir_batch_controller: scans an o_w x o_h output map per channel group and issues
// coordinates to the row routers in batches, then runs tile compare and data drain.
// Optional feature: define IR_BATCH_PERF_CNT_EN for stall-cycle and batch counters.
module ir_batch_controller #(
  parameter int ROW_COUNT  = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int CH_WIDTH   = 4,
  localparam int RID_W     = $clog2(ROW_COUNT)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic                  i_reg_clear,
  input  logic [ADDR_WIDTH-1:0] i_o_w,
  input  logic [ADDR_WIDTH-1:0] i_o_h,
  input  logic [ADDR_WIDTH-1:0] i_stride,
  input  logic [CH_WIDTH-1:0]   i_ch_groups,
  input  logic                  i_rr_ready,
  input  logic                  i_addr_empty,
  input  logic                  i_data_empty,
  input  logic                  i_pop_en,
`ifdef IR_BATCH_PERF_CNT_EN
  output logic [31:0]           o_stall_cycles,
  output logic [15:0]           o_batch_count,
`endif
  output logic [RID_W-1:0]      o_row_id,
  output logic [ROW_COUNT-1:0]  o_row_valid,
  output logic [ADDR_WIDTH-1:0] o_o_x,
  output logic [ADDR_WIDTH-1:0] o_o_y,
  output logic [CH_WIDTH-1:0]   o_ch_group,
  output logic                  o_ag_en,
  output logic                  o_ac_en,
  output logic                  o_tile_read_en,
  output logic                  o_pop_en,
  output logic                  o_ready,
  output logic                  o_reg_clear,
  output logic                  o_context_done,
  output logic                  o_done,
  output logic                  o_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_GEN, S_WSTALL, S_TCMP, S_DRAIN
  } state_t;

  typedef struct packed {
    logic [RID_W-1:0]      row_id;
    logic [ROW_COUNT-1:0]  row_valid;
    logic [ADDR_WIDTH-1:0] o_x;
    logic [ADDR_WIDTH-1:0] o_y;
    logic [CH_WIDTH-1:0]   ch_group;
    logic                  ag_en;
    logic                  ac_en;
    logic                  tile_read_en;
    logic                  pop_en;
    logic                  ready;
    logic                  reg_clear;
    logic                  context_done;
    logic                  done;
    logic                  busy;
  } out_t;

  // Latched configuration plus the running scan position.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] w_m1;
    logic [ADDR_WIDTH-1:0] h_m1;
    logic [ADDR_WIDTH-1:0] stride;
    logic [CH_WIDTH-1:0]   grp_m1;
    logic [ADDR_WIDTH-1:0] x_idx;
    logic [ADDR_WIDTH-1:0] y_idx;
    logic [CH_WIDTH-1:0]   grp_idx;
    logic [ADDR_WIDTH-1:0] x_acc;
    logic [ADDR_WIDTH-1:0] y_acc;
    logic [RID_W-1:0]      slot;
    logic                  grp_end;
    logic                  last_batch;
  } scan_t;

  state_t state;
  out_t   q;
  scan_t  sc;

  logic zero_cfg, y_last, x_last, grp_last, slot_last, drain_exit;

  assign zero_cfg   = (i_o_w == '0) || (i_o_h == '0) || (i_ch_groups == '0);
  assign y_last     = (sc.y_idx == sc.h_m1);
  assign x_last     = (sc.x_idx == sc.w_m1);
  assign grp_last   = y_last && x_last;
  assign slot_last  = (sc.slot == RID_W'(ROW_COUNT - 1));
  assign drain_exit = i_data_empty && !i_pop_en;

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: i_reg_clear is synchronous, so it sits below the async reset branch rather than in the sensitivity list.
    if (i_rst) begin
      state <= S_IDLE;
      q     <= '0;
      sc    <= '0;
    end else if (i_reg_clear) begin
      state <= S_IDLE;
      q     <= '0;
      sc    <= '0;
    end else begin
      q.reg_clear <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (i_en && !q.done) begin
            if (zero_cfg) begin
              q.done <= 1'b1;
            end else begin
              sc.w_m1    <= i_o_w - 1'b1;
              sc.h_m1    <= i_o_h - 1'b1;
              sc.stride  <= i_stride;
              sc.grp_m1  <= i_ch_groups - 1'b1;
              sc.x_idx   <= '0;
              sc.y_idx   <= '0;
              sc.grp_idx <= '0;
              sc.x_acc   <= '0;
              sc.y_acc   <= '0;
              q.busy     <= 1'b1;
              state      <= S_INIT;
            end
          end
        end
        S_INIT: begin
          q.context_done <= 1'b0;
          q.ready        <= 1'b0;
          q.row_id       <= '0;
          q.row_valid    <= '0;
          sc.slot        <= '0;
          state          <= S_GEN;
        end
        S_GEN: begin
          if (i_rr_ready) begin
            q.ag_en              <= 1'b1;
            q.o_x                <= sc.x_acc;
            q.o_y                <= sc.y_acc;
            q.ch_group           <= sc.grp_idx;
            q.row_id             <= sc.slot;
            q.row_valid[sc.slot] <= 1'b1;
            // Advance y fastest, then x, then channel group.
            if (y_last) begin
              sc.y_idx <= '0;
              sc.y_acc <= '0;
              if (x_last) begin
                sc.x_idx   <= '0;
                sc.x_acc   <= '0;
                sc.grp_idx <= sc.grp_idx + 1'b1;
              end else begin
                sc.x_idx <= sc.x_idx + 1'b1;
                sc.x_acc <= sc.x_acc + sc.stride;
              end
            end else begin
              sc.y_idx <= sc.y_idx + 1'b1;
              sc.y_acc <= sc.y_acc + sc.stride;
            end
            if (slot_last || grp_last) begin
              sc.slot       <= '0;
              sc.grp_end    <= grp_last;
              sc.last_batch <= grp_last && (sc.grp_idx == sc.grp_m1);
              state         <= S_WSTALL;
            end else begin
              sc.slot <= sc.slot + 1'b1;
            end
          end else begin
            q.ag_en <= 1'b0;
          end
        end
        S_WSTALL: begin
          q.ag_en        <= 1'b0;
          q.ac_en        <= 1'b1;
          q.tile_read_en <= 1'b1;
          state          <= S_TCMP;
        end
        S_TCMP: begin
          if (i_addr_empty) begin
            q.ac_en        <= 1'b0;
            q.tile_read_en <= 1'b0;
            q.ready        <= 1'b1;
            q.pop_en       <= 1'b1;
            state          <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_exit) begin
            q.pop_en    <= 1'b0;
            q.ready     <= 1'b0;
            q.reg_clear <= 1'b1;
            if (sc.last_batch) begin
              q.done <= 1'b1;
              q.busy <= 1'b0;
              state  <= S_IDLE;
            end else begin
              // Same group next batch: weights stay loaded.
              q.context_done <= !sc.grp_end;
              state          <= S_INIT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_row_id       = q.row_id;
  assign o_row_valid    = q.row_valid;
  assign o_o_x          = q.o_x;
  assign o_o_y          = q.o_y;
  assign o_ch_group     = q.ch_group;
  assign o_ag_en        = q.ag_en;
  assign o_ac_en        = q.ac_en;
  assign o_tile_read_en = q.tile_read_en;
  assign o_pop_en       = q.pop_en;
  assign o_ready        = q.ready;
  assign o_reg_clear    = q.reg_clear;
  assign o_context_done = q.context_done;
  assign o_done         = q.done;
  assign o_busy         = q.busy;

`ifdef IR_BATCH_PERF_CNT_EN
  logic start_evt, stall_evt, batch_evt;

  assign start_evt = (state == S_IDLE) && i_en && !q.done && !zero_cfg;
  assign stall_evt = (state == S_GEN) && !i_rr_ready;
  assign batch_evt = (state == S_DRAIN) && drain_exit;

  // Saturating counters; a new accepted start restarts them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_stall_cycles <= '0;
      o_batch_count  <= '0;
    end else if (i_reg_clear || start_evt) begin
      o_stall_cycles <= '0;
      o_batch_count  <= '0;
    end else begin
      if (stall_evt && (o_stall_cycles != '1)) o_stall_cycles <= o_stall_cycles + 1'b1;
      if (batch_evt && (o_batch_count != '1))  o_batch_count  <= o_batch_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ir_batch_controller.sv
// Self-checking bench for ir_batch_controller: directed plan cases plus randomized
// scans compared against a coordinate-list reference model.
module tb_ir_batch_controller;

  localparam int R  = 4;
  localparam int AW = 8;
  localparam int CW = 4;
  localparam int RW = $clog2(R);
  localparam int CYCLE_LIMIT = 3000;

  typedef struct {
    int x;
    int y;
    int g;
    int rid;
  } coord_t;

  logic          i_clk = 1'b0;
  logic          i_rst, i_en, i_reg_clear;
  logic [AW-1:0] i_o_w, i_o_h, i_stride;
  logic [CW-1:0] i_ch_groups;
  logic          i_rr_ready, i_addr_empty, i_data_empty, i_pop_en;
  logic [RW-1:0] o_row_id;
  logic [R-1:0]  o_row_valid;
  logic [AW-1:0] o_o_x, o_o_y;
  logic [CW-1:0] o_ch_group;
  logic          o_ag_en, o_ac_en, o_tile_read_en, o_pop_en;
  logic          o_ready, o_reg_clear, o_context_done, o_done, o_busy;
`ifdef IR_BATCH_PERF_CNT_EN
  logic [31:0]   o_stall_cycles;
  logic [15:0]   o_batch_count;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  ir_batch_controller #(.ROW_COUNT(R), .ADDR_WIDTH(AW), .CH_WIDTH(CW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_reg_clear(i_reg_clear),
    .i_o_w(i_o_w), .i_o_h(i_o_h), .i_stride(i_stride), .i_ch_groups(i_ch_groups),
    .i_rr_ready(i_rr_ready), .i_addr_empty(i_addr_empty), .i_data_empty(i_data_empty),
    .i_pop_en(i_pop_en),
`ifdef IR_BATCH_PERF_CNT_EN
    .o_stall_cycles(o_stall_cycles), .o_batch_count(o_batch_count),
`endif
    .o_row_id(o_row_id), .o_row_valid(o_row_valid), .o_o_x(o_o_x), .o_o_y(o_o_y),
    .o_ch_group(o_ch_group), .o_ag_en(o_ag_en), .o_ac_en(o_ac_en),
    .o_tile_read_en(o_tile_read_en), .o_pop_en(o_pop_en), .o_ready(o_ready),
    .o_reg_clear(o_reg_clear), .o_context_done(o_context_done), .o_done(o_done),
    .o_busy(o_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] coord_bus();
    return {6'd0, o_o_x, o_o_y, o_ch_group, o_row_id, o_row_valid};
  endfunction

  function automatic logic [31:0] flag_bus();
    return {23'd0, o_ag_en, o_ac_en, o_tile_read_en, o_pop_en, o_ready,
            o_reg_clear, o_context_done, o_done, o_busy};
  endfunction

  task automatic pulse_reg_clear();
    @(negedge i_clk);
    i_reg_clear = 1'b1;
    @(negedge i_clk);
    i_reg_clear = 1'b0;
    check("reg_clear_flags", flag_bus(), 32'd0);
  endtask

  // mode 0: i_rr_ready always high; 1: random handshakes; 2: 3-cycle stall after 2nd coordinate
  task automatic run_scan(input int w, input int h, input int s, input int g, input int mode);
    coord_t exp_q[$];
    coord_t e, prev;
    int nb, cyc, issued, last_issue, bp_left, ctx_cnt, clr_cnt, ac_cnt, k;

    nb = (w * h + R - 1) / R;
    for (int gi = 0; gi < g; gi++)
      for (int xi = 0; xi < w; xi++)
        for (int yi = 0; yi < h; yi++) begin
          k = xi * h + yi;
          exp_q.push_back('{x: (xi * s) % 256, y: (yi * s) % 256, g: gi, rid: k % R});
        end

    cyc = 0; issued = 0; last_issue = 0; bp_left = 0;
    ctx_cnt = 0; clr_cnt = 0; ac_cnt = 0;
    prev = '{x: 0, y: 0, g: 0, rid: 0};

    @(negedge i_clk);
    i_o_w = AW'(w); i_o_h = AW'(h); i_stride = AW'(s); i_ch_groups = CW'(g);
    i_en = 1'b1; i_rr_ready = 1'b1; i_addr_empty = 1'b1; i_data_empty = 1'b1; i_pop_en = 1'b0;
    @(negedge i_clk);
    i_en = 1'b0;
    cyc = 1;
    check("busy_after_start", {31'd0, o_busy}, 32'd1);

    while (cyc < CYCLE_LIMIT) begin
      if (o_ag_en) begin
        if (exp_q.size() == 0) begin
          check("extra_coord", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("coord_x", {24'd0, o_o_x}, 32'(e.x));
          check("coord_y", {24'd0, o_o_y}, 32'(e.y));
          check("coord_grp", {28'd0, o_ch_group}, 32'(e.g));
          check("row_id", {30'd0, o_row_id}, 32'(e.rid));
          check("row_valid", {28'd0, o_row_valid}, 32'((1 << (e.rid + 1)) - 1));
          if (issued == 0 && mode != 1) check("first_latency", 32'(cyc), 32'd3);
          issued++;
          if (mode == 2 && issued == 3) check("bp_low_cycles", 32'(cyc - last_issue - 1), 32'd3);
          if (mode == 2 && issued == 2) bp_left = 3;
          last_issue = cyc;
          prev = e;
        end
      end else if (mode == 2 && issued == 2) begin
        check("bp_hold_y", {24'd0, o_o_y}, 32'(prev.y));
        check("bp_hold_rid", {30'd0, o_row_id}, 32'(prev.rid));
      end
      if (o_ac_en || o_tile_read_en)
        check("ac_tile_pair", {31'd0, o_ac_en}, {31'd0, o_tile_read_en});
      if (o_context_done) ctx_cnt++;
      if (o_reg_clear) clr_cnt++;
      if (o_ac_en) ac_cnt++;
      if (o_done) break;

      if (mode == 1) begin
        i_rr_ready   = ($urandom_range(0, 3) != 0);
        i_addr_empty = ($urandom_range(0, 2) == 0);
        i_data_empty = ($urandom_range(0, 2) == 0);
        i_en         = ($urandom_range(0, 4) == 0);
      end else begin
        i_rr_ready = (bp_left == 0);
        if (bp_left > 0) bp_left--;
      end
      @(negedge i_clk);
      cyc++;
    end

    i_en = 1'b0; i_rr_ready = 1'b1; i_addr_empty = 1'b1; i_data_empty = 1'b1;
    check("scan_done", {31'd0, o_done}, 32'd1);
    check("coords_left", 32'(exp_q.size()), 32'd0);
    check("reg_clear_pulses", 32'(clr_cnt), 32'(g * nb));
    check("context_done_pulses", 32'(ctx_cnt), 32'(g * (nb - 1)));
    if (mode != 1) check("tcmp_cycles", 32'(ac_cnt), 32'(g * nb));
`ifdef IR_BATCH_PERF_CNT_EN
    check("perf_batches", {16'd0, o_batch_count}, 32'(g * nb));
    if (mode != 1) check("perf_stalls", o_stall_cycles, (mode == 2) ? 32'd3 : 32'd0);
`endif

    // A start while o_done is set is ignored; o_done stays sticky.
    @(negedge i_clk);
    i_en = 1'b1;
    @(negedge i_clk);
    i_en = 1'b0;
    check("done_sticky", {30'd0, o_done, o_busy}, 32'd2);
    pulse_reg_clear();
  endtask

  task automatic zero_case(input int w, input int h, input int g);
    logic any_en;
    @(negedge i_clk);
    i_o_w = AW'(w); i_o_h = AW'(h); i_stride = 8'd1; i_ch_groups = CW'(g);
    i_en = 1'b1;
    @(negedge i_clk);
    i_en = 1'b0;
    check("zero_done", {30'd0, o_done, o_busy}, 32'd2);
    any_en = 1'b0;
    for (int c = 0; c < 6; c++) begin
      any_en = any_en | o_ag_en | o_ac_en | o_tile_read_en | o_pop_en;
      @(negedge i_clk);
    end
    check("zero_no_enables", {31'd0, any_en}, 32'd0);
    pulse_reg_clear();
  endtask

  initial begin
    int w, h, s, g, cyc;
    i_rst = 1'b1; i_en = 1'b0; i_reg_clear = 1'b0;
    i_o_w = '0; i_o_h = '0; i_stride = '0; i_ch_groups = '0;
    i_rr_ready = 1'b1; i_addr_empty = 1'b1; i_data_empty = 1'b1; i_pop_en = 1'b0;
    #1;
    check("reset_coords", coord_bus(), 32'd0);
    check("reset_flags", flag_bus(), 32'd0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;

    run_scan(2, 2, 1, 1, 0);   // full batch
    run_scan(1, 5, 2, 1, 0);   // stride with partial final batch
    run_scan(2, 2, 1, 1, 2);   // backpressure
    run_scan(2, 2, 1, 2, 0);   // two channel groups
    zero_case(2, 0, 1);
    zero_case(0, 3, 1);
    zero_case(3, 3, 0);

    // Reset while in TCMP aborts asynchronously.
    @(negedge i_clk);
    i_o_w = 8'd3; i_o_h = 8'd3; i_stride = 8'd1; i_ch_groups = 4'd1;
    i_en = 1'b1; i_addr_empty = 1'b0;
    @(negedge i_clk);
    i_en = 1'b0;
    cyc = 0;
    while (!o_ac_en && cyc < 100) begin
      @(negedge i_clk);
      cyc++;
    end
    check("reach_tcmp", {31'd0, o_ac_en}, 32'd1);
    #2 i_rst = 1'b1;
    #1;
    check("async_reset_coords", coord_bus(), 32'd0);
    check("async_reset_flags", flag_bus(), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0; i_addr_empty = 1'b1;
    run_scan(3, 3, 1, 1, 0);

    for (int t = 0; t < 6; t++) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 6);
      s = $urandom_range(0, 255);
      g = $urandom_range(1, 3);
      run_scan(w, h, s, g, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
